card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_pkg.sv | 18 +
 rtl/card_lfsr.sv | 23 ++
 rtl/card_dealer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared constants and types for the card dealer.
package card_pkg;

    localparam logic [3:0] KEY_DRAW = 4'hA;
    localparam logic [3:0] KEY_END  = 4'hB;
    localparam logic [3:0] KEY_NEW  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DEAL
    } state_t;

    // Fibonacci tap masks: bit k-1 set for tap k
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hD008;

endpackage

// File: rtl/card_lfsr.sv
// Free-running Fibonacci LFSR used as the random source for dealing.
module card_lfsr
    import card_pkg::*;
#(
    parameter int                 LFSR_W    = 8,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] TAPS =
        (LFSR_W == 16) ? LFSR_W'(TAPS_16) : LFSR_W'(TAPS_8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LFSR_SEED;
        else
            state <= {state[LFSR_W-2:0], ^(state & TAPS)};
    end

endmodule

// File: rtl/card_dealer.sv
// Turn-based card dealer: keypad-driven FSM with rejection-sampled cards
// and per-player draw limits.
module card_dealer
    import card_pkg::*;
#(
    parameter int                NUM_PLAYERS = 2,
    parameter int                LFSR_W      = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(8'hA5),
    parameter int                MAX_CARDS   = 5,
    parameter int                MAX_TRIES   = 4,
    localparam int               PW          = $clog2(NUM_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [3:0]               keypad_in,
    output logic [PW-1:0]            whose,
    output logic                     busy,
    output logic                     card_valid,
    output logic [1:0]               card_color,
    output logic [2:0]               card_number,
    output logic                     draw_reject,
    output logic                     turn_pulse,
    output logic [NUM_PLAYERS*4-1:0] card_counts
);

    localparam logic [3:0]    MAX_CNT  = 4'(MAX_CARDS);
    localparam logic [3:0]    LAST_TRY = 4'(MAX_TRIES - 1);
    localparam logic [PW-1:0] LAST_P   = PW'(NUM_PLAYERS - 1);

    state_t            state;
    logic [3:0]        try_cnt;
    logic [3:0]        cnt [NUM_PLAYERS];
    logic [LFSR_W-1:0] lfsr;

    logic [1:0] c;
    logic [2:0] n;
    logic       accept;
    logic [1:0] pick_color;
    logic [2:0] pick_number;
    logic [3:0] cur_cnt;
    logic       unused_lfsr;

    card_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[LFSR_W-1:5];

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_cnt
        assign card_counts[4*p +: 4] = cnt[p];
    end

    assign cur_cnt = cnt[whose];

    // Out-of-range samples fall back to a modulo fold after the last try
    always_comb begin
        c           = lfsr[4:3];
        n           = lfsr[2:0];
        accept      = (c != 2'b11) && (n <= 3'd4);
        pick_color  = c + 2'd1;
        pick_number = n + 3'd1;
        if (!accept) begin
            pick_color  = (c == 2'b11) ? 2'd1 : c + 2'd1;
            pick_number = (n >= 3'd5) ? n - 3'd4 : n + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            try_cnt     <= '0;
            whose       <= '0;
            busy        <= 1'b0;
            card_valid  <= 1'b0;
            card_color  <= '0;
            card_number <= '0;
            draw_reject <= 1'b0;
            turn_pulse  <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++)
                cnt[p] <= '0;
        end else begin
            card_valid  <= 1'b0;
            draw_reject <= 1'b0;
            turn_pulse  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (key_valid) begin
                        case (keypad_in)
                            KEY_DRAW: begin
                                if (cur_cnt < MAX_CNT) begin
                                    state   <= S_DRAW;
                                    try_cnt <= '0;
                                    busy    <= 1'b1;
                                end else begin
                                    draw_reject <= 1'b1;
                                end
                            end
                            KEY_END: begin
                                whose      <= (whose == LAST_P) ? '0 : whose + 1'b1;
                                turn_pulse <= 1'b1;
                            end
                            KEY_NEW: begin
                                whose <= '0;
                                for (int p = 0; p < NUM_PLAYERS; p++)
                                    cnt[p] <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DRAW: begin
                    if (accept || try_cnt == LAST_TRY) begin
                        card_color  <= pick_color;
                        card_number <= pick_number;
                        cnt[whose]  <= cur_cnt + 4'd1;
                        card_valid  <= 1'b1;
                        state       <= S_DEAL;
                    end else begin
                        try_cnt <= try_cnt + 4'd1;
                    end
                end
                S_DEAL: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
